i2s_tx_serializer: RTL and testbench

Transmit-side serial data engine of the I2S transceiver. It follows the word-select line driven by the WS generator (master) or an external master (slave) and pops one word per channel slot from the Tx FIFO. Each word is shifted out MSB-first on sd, aligned to the WS edges for either I2S or MSB-justified timing. It is the data-path counterpart of the WS generator/tracker and sits between the Tx FIFO and the SD pin.

---
 rtl/i2s_tx_serializer_if.sv | 27 ++
 rtl/i2s_tx_serializer.sv | 163 ++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// FIFO-side and pin-side signals of the I2S transmit serializer.
// master: the serializer. slave: the FIFO / pin environment driving it.
interface i2s_tx_serializer_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_empty;
    logic              tx_ren;
    logic              ws;
    logic              sd;

    modport master (
        input  tx_data,
        input  tx_empty,
        input  ws,
        output tx_ren,
        output sd
    );

    modport slave (
        output tx_data,
        output tx_empty,
        output ws,
        input  tx_ren,
        input  sd
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: follows ws, pops one FIFO word per data slot and
// shifts it out MSB-first on sd with I2S (1-bit delay) or MSB-justified timing.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | transmitter disabled, sd held low, no pops
// ST_SYNC  | enabled, waiting for a ws edge into the left level
// ST_SHIFT | framing locked; slots start on ws edges (or mono auto-restart)
module i2s_tx_serializer #(
    parameter int DATA_W = 32
) (
    input  logic                i_sclk,
    input  logic                i_preset,
    input  logic                i_tx_en,
    input  logic                i_standard,
    input  logic                i_frame_size,
    input  logic                i_stereo,
    i2s_tx_serializer_if.master bus,
    output logic                o_chan,
    output logic                o_busy,
    output logic                o_underrun,
    output logic                o_frame_err
);

    localparam int PAD = 32 - DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ws_q;
    logic        r_active;
    logic        r_std;
    logic        r_stereo;
    logic        r_chan;
    logic        r_sd_dly;
    logic        r_underrun;
    logic        r_frame_err;
    logic [31:0] r_shift;
    logic [4:0]  r_cnt;

    logic        w_edge;
    logic        w_left;
    logic        w_carries;
    logic        w_tc;
    logic        w_restart;
    logic        w_start;
    logic        w_stop;
    logic        w_err;
    logic        w_pop;
    logic        w_sd_src;
    logic [31:0] w_load;

    assign w_edge    = (bus.ws != r_ws_q);
    // Left level is ws=0 for I2S and ws=1 for MSB-justified, i.e. ws == standard.
    assign w_left    = (bus.ws == i_standard);
    assign w_carries = i_stereo | w_left;
    assign w_tc      = r_active && (r_cnt == 5'd0);
    // Mono: the left slot repeats back-to-back while ws stays at the left level.
    assign w_restart = w_tc && !r_stereo && (bus.ws == r_std) && !w_edge;
    // Word is left-aligned so the F MSBs go out first and short words zero-fill.
    assign w_load    = 32'(bus.tx_data) << PAD;
    assign w_pop     = w_start && w_carries && !bus.tx_empty && !i_preset;
    assign w_sd_src  = r_active & r_shift[31];

    assign bus.tx_ren  = w_pop;
    assign bus.sd      = r_std ? w_sd_src : r_sd_dly;
    assign o_chan      = r_chan;
    assign o_busy      = r_active;
    assign o_underrun  = r_underrun;
    assign o_frame_err = r_frame_err;

    // State register.
    always_ff @(posedge i_sclk) begin
        if (i_preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slot-start decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_en) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!i_tx_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_edge && w_left) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!i_tx_en) begin
                    // Let the running slot complete; an edge now ends it without a new slot.
                    if (w_edge || !r_active || w_tc) begin
                        w_stop      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_edge) begin
                    w_start = 1'b1;
                    w_err   = r_active && (r_cnt != 5'd0);
                end else if (w_restart) begin
                    w_start = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter, slot config capture and status flags.
    always_ff @(posedge i_sclk) begin
        if (i_preset) begin
            r_ws_q      <= bus.ws;
            r_active    <= 1'b0;
            r_std       <= 1'b0;
            r_stereo    <= 1'b0;
            r_chan      <= 1'b0;
            r_sd_dly    <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
        end else begin
            r_ws_q      <= bus.ws;
            r_sd_dly    <= w_sd_src;
            r_underrun  <= w_start && w_carries && bus.tx_empty;
            r_frame_err <= w_err;
            if (w_start) begin
                r_shift  <= w_pop ? w_load : 32'h0;
                r_cnt    <= i_frame_size ? 5'd31 : 5'd15;
                r_active <= 1'b1;
                r_chan   <= ~w_left;
                r_std    <= i_standard;
                r_stereo <= i_stereo;
            end else if (w_stop || w_tc) begin
                r_active <= 1'b0;
                r_shift  <= '0;
                r_cnt    <= '0;
            end else if (r_active) begin
                r_shift <= {r_shift[30:0], 1'b0};
                r_cnt   <= r_cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: three instances (DATA_W 32/24/16) share the
// control pins and ws; each sees the same FIFO head word right-trimmed to its width.
module tb_i2s_tx_serializer;

    localparam int NI       = 3;
    localparam int SIG_CHAN = 3;
    localparam int SIG_BUSY = 4;
    localparam int SIG_REN  = 5;
    localparam int SIG_UND  = 6;
    localparam int SIG_FERR = 7;

    typedef struct {
        int   cyc;
        int   sig;
        logic val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fifo[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic preset, tx_en, standard, frame_size, stereo, ws;
    logic [NI-1:0] chan, busy, und, ferr;
    logic [NI-1:0] sd_v, ren_v;
    int cyc, checks, failures;

    i2s_tx_serializer_if #(.DATA_W(32)) bus32 ();
    i2s_tx_serializer_if #(.DATA_W(24)) bus24 ();
    i2s_tx_serializer_if #(.DATA_W(16)) bus16 ();

    assign sd_v  = {bus16.sd, bus24.sd, bus32.sd};
    assign ren_v = {bus16.tx_ren, bus24.tx_ren, bus32.tx_ren};

    i2s_tx_serializer #(.DATA_W(32)) u_dut32 (
        .i_sclk(clk), .i_preset(preset), .i_tx_en(tx_en), .i_standard(standard),
        .i_frame_size(frame_size), .i_stereo(stereo), .bus(bus32),
        .o_chan(chan[0]), .o_busy(busy[0]), .o_underrun(und[0]), .o_frame_err(ferr[0]));
    i2s_tx_serializer #(.DATA_W(24)) u_dut24 (
        .i_sclk(clk), .i_preset(preset), .i_tx_en(tx_en), .i_standard(standard),
        .i_frame_size(frame_size), .i_stereo(stereo), .bus(bus24),
        .o_chan(chan[1]), .o_busy(busy[1]), .o_underrun(und[1]), .o_frame_err(ferr[1]));
    i2s_tx_serializer #(.DATA_W(16)) u_dut16 (
        .i_sclk(clk), .i_preset(preset), .i_tx_en(tx_en), .i_standard(standard),
        .i_frame_size(frame_size), .i_stereo(stereo), .bus(bus16),
        .o_chan(chan[2]), .o_busy(busy[2]), .o_underrun(und[2]), .o_frame_err(ferr[2]));

    task automatic push(input int c, input int s, input logic v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    function automatic string sd_name(input int s);
        case (s)
            0:       return "sd_w32";
            1:       return "sd_w24";
            default: return "sd_w16";
        endcase
    endfunction

    task automatic update_bus();
        logic [31:0] h;
        h = (fifo.size() > 0) ? fifo[0] : 32'h0;
        bus32.tx_data  = h;
        bus24.tx_data  = h[31:8];
        bus16.tx_data  = h[31:16];
        bus32.tx_empty = (fifo.size() == 0);
        bus24.tx_empty = (fifo.size() == 0);
        bus16.tx_empty = (fifo.size() == 0);
        bus32.ws = ws;
        bus24.ws = ws;
        bus16.ws = ws;
    endtask

    task automatic check_cycle();
        logic e_ren, e_und, e_ferr;
        e_ren  = 1'b0;
        e_und  = 1'b0;
        e_ferr = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].sig)
                    SIG_REN:  e_ren  = sb[i].val;
                    SIG_UND:  e_und  = sb[i].val;
                    SIG_FERR: e_ferr = sb[i].val;
                    SIG_CHAN: for (int j = 0; j < NI; j++) compare($sformatf("chan[%0d]", j), chan[j], sb[i].val);
                    SIG_BUSY: for (int j = 0; j < NI; j++) compare($sformatf("busy[%0d]", j), busy[j], sb[i].val);
                    default:  compare(sd_name(sb[i].sig), sd_v[sb[i].sig], sb[i].val);
                endcase
                sb.delete(i);
            end
        end
        for (int j = 0; j < NI; j++) begin
            compare($sformatf("tx_ren[%0d]", j), ren_v[j], e_ren);
            compare($sformatf("underrun[%0d]", j), und[j], e_und);
            compare($sformatf("frame_err[%0d]", j), ferr[j], e_ferr);
        end
    endtask

    // One clock cycle: apply inputs, check mid-cycle, advance past the next edge.
    task automatic step();
        logic popped;
        update_bus();
        #5;
        check_cycle();
        popped = ren_v[0];
        @(posedge clk);
        #1;
        if (popped && fifo.size() > 0) fifo.delete(0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Expected results of a slot starting in the current cycle.
    task automatic slot(input bit do_edge, input logic new_ws, input int nbits);
        bit          left, carries;
        logic [31:0] w;
        int          dly;
        if (do_edge) ws = new_ws;
        left    = (ws == standard);
        carries = stereo || left;
        w       = 32'h0;
        if (carries && fifo.size() > 0) begin
            w = fifo[0];
            push(cyc, SIG_REN, 1'b1);
        end else if (carries) begin
            push(cyc + 1, SIG_UND, 1'b1);
        end
        push(cyc + 1, SIG_CHAN, !left);
        dly = standard ? 1 : 2;
        for (int k = 0; k < nbits; k++) begin
            push(cyc + dly + k, 0, w[31-k]);
            push(cyc + dly + k, 1, (k < 24) ? w[31-k] : 1'b0);
            push(cyc + dly + k, 2, (k < 16) ? w[31-k] : 1'b0);
            if (standard) push(cyc + 1 + k, SIG_BUSY, 1'b1);
        end
    endtask

    task automatic expect_quiet(input int from, input int n, input bit with_busy);
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < NI; s++) push(from + k, s, 1'b0);
            if (with_busy) push(from + k, SIG_BUSY, 1'b0);
        end
    endtask

    initial begin
        cyc = 0; checks = 0; failures = 0;
        preset = 1'b1; tx_en = 1'b0; standard = 1'b1; frame_size = 1'b1; stereo = 1'b1; ws = 1'b0;
        update_bus();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        expect_quiet(cyc, 1, 1'b1);
        push(cyc, SIG_CHAN, 1'b0);
        step();

        // MSB-justified stereo F=32; empty FIFO at a slot start
        preset = 1'b0; tx_en = 1'b1;
        fifo.push_back(32'hA5A5_0F0F);
        fifo.push_back(32'h1234_5678);
        fifo.push_back(32'h8001_7777);
        run(3);
        slot(1, 1'b1, 32); run(32);
        slot(1, 1'b0, 32); run(32);
        slot(1, 1'b1, 32); run(32);
        slot(1, 1'b0, 32); run(5);
        fifo.push_back(32'hCAFE_F00D);
        run(27);
        slot(1, 1'b1, 32); run(32);
        expect_quiet(cyc + 1, 4, 1'b1);
        run(6);

        // Early ws edge: frame error, new slot starts cleanly
        fifo.push_back(32'h0F0F_F0F0);
        fifo.push_back(32'h3C3C_C3C3);
        slot(1, 1'b0, 10); run(10);
        push(cyc + 1, SIG_FERR, 1'b1);
        slot(1, 1'b1, 32); run(32);
        tx_en = 1'b0;
        run(2);

        // Enable mid left frame, mono: waits for a left edge; auto-restart; right slots silent
        stereo = 1'b0; tx_en = 1'b1;
        expect_quiet(cyc, 40, 1'b1);
        run(8);
        ws = 1'b0;
        run(32);
        fifo.push_back(32'h1111_2222);
        fifo.push_back(32'h9999_6666);
        fifo.push_back(32'hF0E1_D2C3);
        fifo.push_back(32'h5555_AAAA);
        slot(1, 1'b1, 32); run(32);
        slot(0, 1'b1, 32); run(32);
        slot(0, 1'b1, 32); run(32);
        slot(1, 1'b0, 32); run(32);
        slot(1, 1'b1, 32); run(32);
        tx_en = 1'b0;
        expect_quiet(cyc + 1, 3, 1'b1);
        run(4);

        // I2S stereo F=16: one-bit delay, tx_en drop finishes the slot
        standard = 1'b0; frame_size = 1'b0; stereo = 1'b1; tx_en = 1'b1;
        fifo.push_back(32'hABCD_EF00);
        fifo.push_back(32'h8001_5A5A);
        fifo.push_back(32'h1357_9BDF);
        run(3);
        slot(1, 1'b0, 16); run(16);
        slot(1, 1'b1, 16); run(16);
        slot(1, 1'b0, 16); run(5);
        tx_en = 1'b0;
        run(11);
        ws = 1'b1;
        expect_quiet(cyc + 2, 4, 1'b0);
        run(6);

        // Reset in the middle of a slot, together with a ws edge
        standard = 1'b1; frame_size = 1'b1; stereo = 1'b1; tx_en = 1'b1; ws = 1'b0;
        fifo.push_back(32'hFFFF_FFFF);
        fifo.push_back(32'h7E7E_7E7E);
        run(3);
        slot(1, 1'b1, 6); run(6);
        ws = 1'b0; preset = 1'b1;
        expect_quiet(cyc + 1, 1, 1'b1);
        push(cyc + 1, SIG_CHAN, 1'b0);
        step();
        preset = 1'b0;
        run(3);
        slot(1, 1'b1, 32); run(32);
        tx_en = 1'b0;
        run(3);

        compare("scoreboard_drained", sb.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
